// File: rtl/val_find_stream_if.sv
// Sample-stream and result bundle for val_find_stream.
// The master side is the sample source and result consumer; the slave side is the finder.
interface val_find_stream_if #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8
);
   localparam int IDX_W = $clog2(DEPTH);

   logic              start;
   logic              mode;
   logic              tie_last;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic              busy;
   logic [DATA_W-1:0] value;
   logic [IDX_W-1:0]  index;
   logic              done;

   modport master (
      output start, mode, tie_last, data_valid, data,
      input  busy, value, index, done
   );

   modport slave (
      input  start, mode, tie_last, data_valid, data,
      output busy, value, index, done
   );
endinterface

// File: rtl/val_find_stream.sv
// Streaming extreme-value finder: scans DEPTH samples per frame and reports the
// max or min value and its index, with first/last tie policy and optional signed compare.
module val_find_stream #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input logic              i_clk,
   input logic              i_rst,
   val_find_stream_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  cnt;
   logic [DATA_W-1:0] best_val;
   logic [IDX_W-1:0]  best_idx;
   logic              mode_q;
   logic              tie_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] value_q;
   logic [IDX_W-1:0]  index_q;

   logic              gt;
   logic              lt;
   logic              eq;
   logic              take;
   logic [DATA_W-1:0] cand_val;
   logic [IDX_W-1:0]  cand_idx;

   always_comb begin
      gt = 1'b0;
      lt = 1'b0;
      if (SIGNED) begin
         gt = $signed(bus.data) > $signed(best_val);
         lt = $signed(bus.data) < $signed(best_val);
      end else begin
         gt = bus.data > best_val;
         lt = bus.data < best_val;
      end
      eq   = bus.data == best_val;
      // Sample 0 always loads, so the stale best from the previous frame never leaks in.
      take = (cnt == '0) || (mode_q ? lt : gt) || (tie_q && eq);
      cand_val = take ? bus.data : best_val;
      cand_idx = take ? cnt : best_idx;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         best_val <= '0;
         best_idx <= '0;
         mode_q   <= 1'b0;
         tie_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         value_q  <= '0;
         index_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mode_q <= bus.mode;
                  tie_q  <= bus.tie_last;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= SCAN;
               end
            end
            SCAN: begin
               if (bus.data_valid) begin
                  best_val <= cand_val;
                  best_idx <= cand_idx;
                  if (cnt == LAST) begin
                     // Publish the candidate directly so the result lands with o_done.
                     value_q <= cand_val;
                     index_q <= cand_idx;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state   <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.value = value_q;
   assign bus.index = index_q;
endmodule

// File: tb/tb_val_find_stream.sv
// Directed bench for val_find_stream: an unsigned and a signed instance see the
// same stimulus; expected results are hand-computed per frame.
module tb_val_find_stream;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   val_find_stream_if #(.DATA_W(4), .DEPTH(8)) bus_u ();
   val_find_stream_if #(.DATA_W(4), .DEPTH(8)) bus_s ();

   val_find_stream #(.DATA_W(4), .DEPTH(8), .SIGNED(1'b0)) dut_u (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_u.slave)
   );

   val_find_stream #(.DATA_W(4), .DEPTH(8), .SIGNED(1'b1)) dut_s (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_s.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic start, input logic mode, input logic tie,
                        input logic valid, input logic [3:0] data);
      bus_u.start = start;  bus_s.start = start;
      bus_u.mode = mode;    bus_s.mode = mode;
      bus_u.tie_last = tie; bus_s.tie_last = tie;
      bus_u.data_valid = valid; bus_s.data_valid = valid;
      bus_u.data = data;    bus_s.data = data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Samples packed low nibble first; stalls[k] inserts two invalid cycles after sample k.
   task automatic run_frame(input string name, input logic mode, input logic tie,
                            input logic [31:0] v, input logic [7:0] stalls,
                            input int ev, input int ei,
                            input bit chk_s, input int sev, input int sei);
      drive(1'b1, mode, tie, 1'b0, 4'd0);
      step();
      // Flip mode/tie for the rest of the frame: they must already be latched.
      drive(1'b0, ~mode, ~tie, 1'b0, 4'd0);
      check({name, "_busy_start"}, bus_u.busy, 1);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, ~mode, ~tie, 1'b1, v[4*k +: 4]);
         step();
         drive(1'b0, ~mode, ~tie, 1'b0, 4'd0);
         if (k < 7) begin
            check({name, "_done_early"}, bus_u.done, 0);
            check({name, "_busy_mid"}, bus_u.busy, 1);
            if (stalls[k]) begin
               repeat (2) begin
                  step();
                  check({name, "_done_stall"}, bus_u.done, 0);
                  check({name, "_busy_stall"}, bus_u.busy, 1);
               end
            end
         end
      end
      check({name, "_done"}, bus_u.done, 1);
      check({name, "_value"}, bus_u.value, ev);
      check({name, "_index"}, bus_u.index, ei);
      check({name, "_busy_end"}, bus_u.busy, 0);
      if (chk_s) begin
         check({name, "_s_done"}, bus_s.done, 1);
         check({name, "_s_value"}, bus_s.value, sev);
         check({name, "_s_index"}, bus_s.index, sei);
      end
      step();
      check({name, "_done_pulse"}, bus_u.done, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      step();
      step();
      check("rst_busy", bus_u.busy, 0);
      check("rst_done", bus_u.done, 0);
      check("rst_value", bus_u.value, 0);
      check("rst_index", bus_u.index, 0);
      rst = 1'b0;
      step();

      // samples 3,9,2,9,1,0,7,5
      run_frame("max_first", 1'b0, 1'b0, 32'h5701_9293, 8'h00, 9, 1, 1'b0, 0, 0);
      run_frame("max_last",  1'b0, 1'b1, 32'h5701_9293, 8'h00, 9, 3, 1'b0, 0, 0);
      run_frame("eq_first",  1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00, 15, 0, 1'b0, 0, 0);
      run_frame("eq_last",   1'b0, 1'b1, 32'hFFFF_FFFF, 8'h00, 15, 7, 1'b0, 0, 0);
      run_frame("min_stall", 1'b1, 1'b0, 32'h5701_9293, 8'b0001_0010, 0, 5, 1'b0, 0, 0);

      // Held result: a new frame in progress must not disturb 9/1; start in SCAN is ignored.
      run_frame("pre_hold", 1'b0, 1'b0, 32'h5701_9293, 8'h00, 9, 1, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step();
      for (int k = 0; k < 8; k++) begin
         drive((k == 3) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
         step();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
         if (k < 7) begin
            check("hold_value", bus_u.value, 9);
            check("hold_index", bus_u.index, 1);
            check("hold_done", bus_u.done, 0);
         end
      end
      check("hold_new_done", bus_u.done, 1);
      check("hold_new_value", bus_u.value, 15);
      check("hold_new_index", bus_u.index, 0);
      step();

      // Reset mid-frame after a 9/1 result.
      run_frame("pre_rst", 1'b0, 1'b0, 32'h5701_9293, 8'h00, 9, 1, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
         step();
      end
      rst = 1'b1;
      #2;
      check("midrst_value", bus_u.value, 0);
      check("midrst_index", bus_u.index, 0);
      check("midrst_busy", bus_u.busy, 0);
      check("midrst_done", bus_u.done, 0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 9; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 4'(k + 3));
         step();
         check("norun_done", bus_u.done, 0);
         check("norun_busy", bus_u.busy, 0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      check("norun_value", bus_u.value, 0);
      step();

      // samples 8,15,1,14,2,3,0,7
      run_frame("sgn_max", 1'b0, 1'b0, 32'h7032_E1F8, 8'h00, 15, 1, 1'b1, 7, 7);
      run_frame("sgn_min", 1'b1, 1'b0, 32'h7032_E1F8, 8'h00, 0, 6, 1'b1, 8, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/val_find_stream.md
Name: val_find_stream

Overview:
- Parametrised successor to the fixed 8-entry, 4-bit max finder.
- Scans a frame of DEPTH streamed samples and reports the extreme value and its index.
- Selectable max/min mode, selectable tie policy (first or last occurrence), optional signed compare, start/done handshake.
- Sits between a sample source (ROM reader, ADC buffer) and downstream control logic that consumes the result.

Parameters:
- DATA_W, 4, sample width in bits (>=1)
- DEPTH, 8, samples per frame (>=2)
- IDX_W, $clog2(DEPTH), index width; derived, not overridden
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  begin a frame; sampled only in IDLE
- i_mode  in  1  0 = find max, 1 = find min; latched on accepted start
- i_tie_last  in  1  0 = keep first occurrence on tie, 1 = keep last; latched on accepted start
- i_data_valid  in  1  sample present on i_data this cycle
- i_data  in  DATA_W  sample
- o_busy  out  1  high in SCAN
- o_value  out  DATA_W  extreme value of last completed frame
- o_index  out  IDX_W  position (0..DEPTH-1) of o_value in frame order
- o_done  out  1  one-cycle pulse: result updated

Behaviour:
- Reset: one clock; asynchronous active-high i_rst. While i_rst is high, state is IDLE and o_busy, o_done, o_value, o_index, the sample counter, the working best and the latched mode/tie all read 0. Assertion mid-frame discards the partial frame.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - i_start=1 latches i_mode and i_tie_last, clears the counter, and moves to SCAN next cycle.
  - i_data_valid is ignored in IDLE.
- SCAN:
  - o_busy=1.
  - Each cycle with i_data_valid=1 consumes one sample; cycles with valid low are stalls with no state change.
  - Sample 0 loads best value/index unconditionally.
  - Sample k>0 replaces best when strictly better. Better means greater for max and smaller for min.
  - If i_tie_last=1, a sample equal to best also replaces it.
  - Compare is unsigned or signed per SIGNED.
  - The counter increments per consumed sample. Consuming sample DEPTH-1 moves the FSM to DONE.
  - i_start is ignored in SCAN.
  - Mode/tie inputs changing mid-frame have no effect.
- DONE (one cycle):
  - o_done=1.
  - o_value/o_index take the working best in the same edge that enters DONE, so they are valid when o_done is high.
  - Next state is IDLE.
  - i_start and i_data_valid are ignored in DONE.
- Latency: o_done is high exactly one cycle after the clock edge that consumed the last sample. Back-to-back frames: the earliest next start is the cycle after DONE (IDLE).
- o_value/o_index hold between frames. They change only on entry to DONE or on reset; a new frame in progress does not disturb them.
- Counter wraps never: the counter is cleared on start, and the terminal count is DEPTH-1. When DEPTH is not a power of two, counter values >= DEPTH are unreachable.
- No internal storage of the frame; area is O(DATA_W + IDX_W).

Test Plan:
- Max, first tie: DEPTH=8, DATA_W=4, mode=0, tie_last=0, samples 3,9,2,9,1,0,7,5 on consecutive cycles -> o_done one cycle after the 8th sample; o_value=9, o_index=1.
- Max, last tie: same samples with tie_last=1 -> o_value=9, o_index=3. All-equal frame of 15s -> index 0 with tie_last=0, index 7 with tie_last=1.
- Min mode with stalls: mode=1, same samples, i_data_valid low for 2 cycles after samples 2 and 5 -> o_value=0, o_index=5; o_done asserts only after the 8th valid sample; o_busy high for the whole frame.
- Reset mid-frame: frame with result 9/1 completed, new frame started, i_rst pulsed after 4 samples -> o_value=0, o_index=0, o_busy=0, state IDLE. The following 8 valid samples without i_start produce no o_done.
- Signed: SIGNED=1, DATA_W=4, mode=0, samples 8,15,1,14,2,3,0,7 -> o_value=7, o_index=7. Mode=1 -> o_value=8 (-8), o_index=0.
- Held result: after a frame gives 9/1, start a new frame and feed 3 samples -> o_value/o_index stay 9/1 until the new o_done. i_start pulsed during SCAN is ignored; frame length stays 8.
